// File: rtl/fft_in_sequencer.sv
// fft_in_sequencer: captures a frame of 2^DEPTH_LOG2 audio samples on software
// command and plays it out one sample at a time on the FFT input PIO word.
// Provides a small Avalon-MM control/status slave and a frame-ready interrupt.
module fft_in_sequencer #(
    parameter int DEPTH_LOG2 = 8,
    parameter int SAMPLE_W   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic [1:0]          address,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [31:0]         pio_data,
    output logic                irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;

    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_MAX  = {DEPTH_LOG2{1'b1}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    // Control state
    logic [1:0]            state_r;
    logic [1:0]            state_next_s;
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] wr_ptr_next_s;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_next_s;

    // Decoded register writes
    logic ctrl_wr_s;
    logic start_s;
    logic abort_s;
    logic next_wr_s;
    logic mem_wr_s;
    logic last_next_s;

    // Frame buffer and its registered read port
    logic [SAMPLE_W-1:0]   mem_r [0:DEPTH-1];
    logic [SAMPLE_W-1:0]   rd_data_r;
    logic [DEPTH_LOG2-1:0] rd_addr_q_r;
    logic                  rd_valid_r;

    // Output registers
    logic [31:0] readdata_r;
    logic [31:0] read_mux_s;
    logic [31:0] pio_data_r;
    logic        irq_r;

    // Only the two command bits of CTRL carry meaning
    logic unused_writedata_s;
    assign unused_writedata_s = ^writedata[31:2];

    // ABORT dominates START when both bits arrive in the same write
    assign ctrl_wr_s = write && (address == 2'd0);
    assign abort_s   = ctrl_wr_s && writedata[1];
    assign start_s   = ctrl_wr_s && writedata[0] && !writedata[1];
    assign next_wr_s = write && (address == 2'd1) && (state_r == ST_READY);

    // Next-state, pointer and buffer-write decisions for the sequencer
    always_comb begin
        state_next_s  = state_r;
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        mem_wr_s      = 1'b0;
        last_next_s   = 1'b0;
        if (abort_s) begin
            state_next_s  = ST_IDLE;
            wr_ptr_next_s = PTR_ZERO;
            rd_ptr_next_s = PTR_ZERO;
        end else if (start_s) begin
            // A strobe coinciding with START is dropped; capture restarts at 0
            state_next_s  = ST_CAPTURE;
            wr_ptr_next_s = PTR_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        mem_wr_s      = 1'b1;
                        wr_ptr_next_s = wr_ptr_r + PTR_ONE;
                        if (wr_ptr_r == PTR_MAX) begin
                            state_next_s  = ST_READY;
                            rd_ptr_next_s = PTR_ZERO;
                        end else begin
                            state_next_s = ST_CAPTURE;
                        end
                    end else begin
                        state_next_s = ST_CAPTURE;
                    end
                end
                ST_READY: begin
                    if (next_wr_s) begin
                        rd_ptr_next_s = rd_ptr_r + PTR_ONE;
                        if (rd_ptr_r == PTR_MAX) begin
                            state_next_s = ST_IDLE;
                            last_next_s  = 1'b1;
                        end else begin
                            state_next_s = ST_READY;
                        end
                    end else begin
                        state_next_s = ST_READY;
                    end
                end
                default: begin
                    state_next_s  = ST_IDLE;
                    wr_ptr_next_s = PTR_ZERO;
                    rd_ptr_next_s = PTR_ZERO;
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            state_r  <= state_next_s;
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
        end
    end

    // Frame buffer: single write port, registered read of the playout slot
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            mem_r[wr_ptr_r] <= sample_in;
        end
        rd_data_r <= mem_r[rd_ptr_r];
    end

    // Read-side qualifier: the read data is usable only if the pointer it was
    // fetched with stays put and the frame is still being played out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_r  <= 1'b0;
            rd_addr_q_r <= PTR_ZERO;
        end else begin
            rd_valid_r  <= (state_r == ST_READY) && (state_next_s == ST_READY) && !next_wr_s;
            rd_addr_q_r <= rd_ptr_r;
        end
    end

    // Avalon read multiplexer
    always_comb begin
        read_mux_s = 32'h0000_0000;
        case (address)
            2'd0:    read_mux_s = {30'h0000_0000, state_r == ST_READY, state_r == ST_CAPTURE};
            2'd1:    read_mux_s = 32'(wr_ptr_r);
            2'd2:    read_mux_s = 32'(rd_ptr_r);
            2'd3:    read_mux_s = 32'h0000_0000;
            default: read_mux_s = 32'h0000_0000;
        endcase
    end

    // Registered outputs; irq is held one extra cycle after the final NEXT so
    // it drops together with the PIO valid bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'h0000_0000;
            pio_data_r <= 32'h0000_0000;
            irq_r      <= 1'b0;
        end else begin
            readdata_r <= read_mux_s;
            irq_r      <= (state_next_s == ST_READY) || last_next_s;
            if (rd_valid_r) begin
                pio_data_r <= {1'b1, 15'(rd_addr_q_r), 16'(rd_data_r)};
            end else begin
                pio_data_r <= 32'h0000_0000;
            end
        end
    end

    assign readdata = readdata_r;
    assign pio_data = pio_data_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_fft_in_sequencer.sv
// Self-checking bench for fft_in_sequencer with an 8-sample frame: a constant
// vector table for a full frame, hand-written timing sequences, and random
// traffic checked against a queue-based behavioural model.
module tb_fft_in_sequencer;

    localparam int N = 8;

    logic        clk;
    logic        reset_n;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] pio_data;
    logic        irq;

    int n_tests;
    int n_fail;

    // Behavioural model: state 0 idle, 1 capturing, 2 frame ready
    int          m_state;
    int          m_rd;
    logic [15:0] m_cap[$];
    logic [15:0] m_frame[N];

    typedef struct {
        logic [1:0]  kind;     // 0 strobe, 1 CTRL write, 2 NEXT
        logic [15:0] val;
        logic [31:0] exp_pio;
        logic        exp_irq;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs[17];

    fft_in_sequencer #(.DEPTH_LOG2(3), .SAMPLE_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in),
        .sample_valid(sample_valid), .address(address), .write(write),
        .writedata(writedata), .readdata(readdata), .pio_data(pio_data), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_rd    = 0;
        m_cap.delete();
    endtask

    task automatic model_step(input logic sv, input logic [15:0] s, input logic we,
                              input logic [1:0] a, input logic [31:0] wd);
        bit ab, st, nx;
        ab = we && (a == 2'd0) && wd[1];
        st = we && (a == 2'd0) && wd[0] && !wd[1];
        nx = we && (a == 2'd1);
        if (ab) begin
            m_state = 0;
            m_rd    = 0;
            m_cap.delete();
        end else if (st) begin
            m_state = 1;
            m_cap.delete();
        end else if (m_state == 1 && sv) begin
            m_cap.push_back(s);
            if (m_cap.size() == N) begin
                for (int i = 0; i < N; i++) m_frame[i] = m_cap[i];
                m_cap.delete();
                m_state = 2;
                m_rd    = 0;
            end
        end else if (m_state == 2 && nx) begin
            m_rd++;
            if (m_rd == N) begin
                m_rd    = 0;
                m_state = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_pio();
        logic [31:0] r;
        r = 32'h0;
        if (m_state == 2) r = {1'b1, 15'(m_rd), m_frame[m_rd]};
        return r;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [1:0] a);
        logic [31:0] r;
        r = 32'h0;
        case (a)
            2'd0: r = {30'h0, m_state == 2, m_state == 1};
            2'd1: r = (m_state == 1) ? 32'(m_cap.size()) : 32'h0;
            2'd2: r = 32'(m_rd);
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Drive one cycle from a falling edge; returns at the next falling edge
    task automatic step(input logic sv, input logic [15:0] s, input logic we,
                        input logic [1:0] a, input logic [31:0] wd);
        sample_valid = sv;
        sample_in    = s;
        write        = we;
        address      = a;
        writedata    = wd;
        @(posedge clk);
        if (reset_n) model_step(sv, s, we, a, wd);
        @(negedge clk);
        sample_valid = 1'b0;
        write        = 1'b0;
    endtask

    task automatic idle(input logic [1:0] a);
        step(1'b0, 16'h0, 1'b0, a, 32'h0);
    endtask

    task automatic strobe(input logic [15:0] s);
        step(1'b1, s, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic ctrl(input logic [31:0] wd);
        step(1'b0, 16'h0, 1'b1, 2'd0, wd);
    endtask

    task automatic next_wr();
        step(1'b0, 16'h0, 1'b1, 2'd1, 32'h0);
    endtask

    task automatic capture_frame(input logic [15:0] base);
        ctrl(32'h1);
        for (int i = 0; i < N; i++) strobe(base + 16'(i));
    endtask

    initial begin
        logic [15:0] s16;
        logic [31:0] p32;
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        reset_n = 1'b0;
        sample_valid = 1'b0; sample_in = 16'h0; write = 1'b0; address = 2'd0; writedata = 32'h0;

        // Full-frame vectors
        vecs[0] = '{2'd1, 16'h0001, 32'h0, 1'b0, 32'h1};
        for (int i = 0; i < N; i++) begin
            s16 = 16'h1000 + 16'(i);
            vecs[1 + i] = '{2'd0, s16, (i == N - 1) ? 32'h8000_1000 : 32'h0,
                            i == N - 1, (i == N - 1) ? 32'h2 : 32'h1};
        end
        for (int k = 1; k < N; k++) begin
            p32 = 32'h8000_1000 | (32'(k) << 16) | 32'(k);
            vecs[N + k] = '{2'd2, 16'h0, p32, 1'b1, 32'h2};
        end
        vecs[16] = '{2'd2, 16'h0, 32'h0, 1'b0, 32'h0};

        // Reset held with activity on the inputs
        @(negedge clk);
        step(1'b1, 16'h1234, 1'b1, 2'd0, 32'h1);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_pio", pio_data, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        step(1'b1, 16'h5678, 1'b1, 2'd1, 32'h0);
        chk("rst_pio2", pio_data, 32'h0);
        reset_n = 1'b1;
        idle(2'd0);
        chk("rst_status", readdata, 32'h0);

        // Table-driven full frame
        for (int v = 0; v < 17; v++) begin
            case (vecs[v].kind)
                2'd0:    strobe(vecs[v].val);
                2'd1:    ctrl(32'(vecs[v].val));
                default: next_wr();
            endcase
            idle(2'd0);
            idle(2'd0);
            chk($sformatf("vec%0d_pio", v), pio_data, vecs[v].exp_pio);
            chk($sformatf("vec%0d_irq", v), {31'h0, irq}, {31'h0, vecs[v].exp_irq});
            chk($sformatf("vec%0d_status", v), readdata, vecs[v].exp_status);
        end

        // Frame entry and NEXT cycle timing
        ctrl(32'h1);
        for (int i = 0; i < N - 1; i++) strobe(16'h3000 + 16'(i));
        strobe(16'h3007);
        chk("entry_irq_T", {31'h0, irq}, 32'h1);
        chk("entry_valid_T", {31'h0, pio_data[31]}, 32'h0);
        idle(2'd0);
        chk("entry_valid_T1", {31'h0, pio_data[31]}, 32'h0);
        idle(2'd0);
        chk("entry_pio_T2", pio_data, 32'h8000_3000);
        next_wr();
        chk("next_irq_T", {31'h0, irq}, 32'h1);
        idle(2'd0);
        chk("next_valid_T1", {31'h0, pio_data[31]}, 32'h0);
        idle(2'd0);
        chk("next_pio_T2", pio_data, 32'h8001_3001);
        next_wr();
        next_wr();
        idle(2'd0);
        idle(2'd0);
        chk("b2b_next_pio", pio_data, 32'h8003_3003);
        for (int i = 0; i < 4; i++) next_wr();
        idle(2'd0);
        idle(2'd0);
        chk("last_pio", pio_data, 32'h8007_3007);
        next_wr();
        chk("final_irq_T", {31'h0, irq}, 32'h1);
        idle(2'd0);
        chk("final_irq_T1", {31'h0, irq}, 32'h0);
        chk("final_valid_T1", {31'h0, pio_data[31]}, 32'h0);
        // STATUS lags a write by one cycle
        ctrl(32'h1);
        chk("status_lag_T", readdata, 32'h0);
        idle(2'd0);
        chk("status_lag_T1", readdata, 32'h1);
        ctrl(32'h2);
        chk("abort_lag_T", readdata, 32'h1);
        idle(2'd0);
        chk("abort_lag_T1", readdata, 32'h0);

        // START coinciding with a strobe drops that sample
        step(1'b1, 16'hAAAA, 1'b1, 2'd0, 32'h1);
        for (int i = 0; i < N; i++) strobe(16'(i));
        idle(2'd0);
        idle(2'd0);
        chk("start_sv_pio", pio_data, 32'h8000_0000);
        ctrl(32'h2);

        // Restart mid-capture keeps only the final frame
        ctrl(32'h1);
        for (int i = 0; i < 5; i++) strobe(16'h5500 + 16'(i));
        capture_frame(16'h2000);
        idle(2'd0);
        idle(2'd0);
        chk("restart_pio0", pio_data, 32'h8000_2000);
        for (int i = 0; i < N - 1; i++) next_wr();
        idle(2'd0);
        idle(2'd0);
        chk("restart_pio7", pio_data, 32'h8007_2007);

        // START|ABORT together during capture
        ctrl(32'h1);
        strobe(16'h0101);
        strobe(16'h0202);
        ctrl(32'h3);
        idle(2'd0);
        chk("startabort_status", readdata, 32'h0);
        idle(2'd1);
        chk("startabort_wr", readdata, 32'h0);

        // NEXT and strobes ignored outside their states
        next_wr();
        strobe(16'h7777);
        idle(2'd2);
        chk("idle_next_rd", readdata, 32'h0);
        idle(2'd1);
        chk("idle_sv_wr", readdata, 32'h0);
        ctrl(32'h1);
        strobe(16'h0001);
        strobe(16'h0002);
        next_wr();
        idle(2'd2);
        chk("cap_next_rd", readdata, 32'h0);
        idle(2'd1);
        chk("cap_wr", readdata, 32'h2);

        // Reset pulse while playing out at rd_ptr 3
        capture_frame(16'h4000);
        for (int i = 0; i < 3; i++) next_wr();
        idle(2'd2);
        idle(2'd2);
        chk("prereset_pio", pio_data, 32'h8003_4003);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_pio", pio_data, 32'h0);
        chk("midrst_irq", {31'h0, irq}, 32'h0);
        chk("midrst_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        capture_frame(16'h5000);
        idle(2'd0);
        idle(2'd0);
        chk("postrst_pio", pio_data, 32'h8000_5000);
        chk("postrst_status", readdata, 32'h2);

        // Random traffic against the model
        for (int t = 0; t < 400; t++) begin
            int r;
            logic [1:0] ra;
            r  = $urandom_range(0, 99);
            ra = 2'($urandom_range(0, 3));
            if (r < 55)      step(1'b1, 16'($urandom), 1'b0, 2'd0, 32'h0);
            else if (r < 77) step(1'($urandom_range(0, 1)), 16'($urandom), 1'b1, 2'd1, $urandom);
            else if (r < 81) step(1'($urandom_range(0, 1)), 16'($urandom), 1'b1, 2'd0, 32'h1);
            else if (r < 83) step(1'b0, 16'h0, 1'b1, 2'd0, 32'h2);
            else if (r < 84) step(1'b1, 16'($urandom), 1'b1, 2'd0, 32'h3);
            else if (r < 90) step(1'b1, 16'($urandom), 1'b1, 2'($urandom_range(2, 3)), $urandom);
            else             step(1'b1, 16'($urandom), 1'b1, 2'd0, $urandom & 32'hFFFF_FFFC);
            idle(ra);
            idle(ra);
            chk("rand_pio", pio_data, exp_pio());
            chk("rand_irq", {31'h0, irq}, {31'h0, m_state == 2});
            chk("rand_readdata", readdata, exp_reg(ra));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_in_sequencer.md
# fft_in_sequencer

Capture-and-playout sequencer for the FFT input path of the Nios II VGA spectrum analyser. It collects a frame of 2^DEPTH_LOG2 audio samples into an internal buffer on command from software. It then presents the frame one sample at a time on a 32-bit word that drives the FFT input PIO port, advancing under software control. It also provides a small Avalon-MM control/status slave and a frame-ready interrupt.

## Interface
- DEPTH_LOG2, 8: frame length is 2^DEPTH_LOG2 samples; legal range 2..15.
- SAMPLE_W, 16: sample width; legal range 1..16. Samples are zero-extended to 16 bits in pio_data.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sample_in  in  SAMPLE_W  audio sample; qualified by sample_valid.
- sample_valid  in  1  one-cycle strobe per new sample.
- address  in  2  Avalon slave word address.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  registered Avalon read data; zero-wait, one-cycle latency.
- pio_data  out  32  word to the FFT input PIO:
  - [31] valid.
  - [30:16] rd_ptr, zero-extended.
  - [15:0] sample.
- irq  out  1  level interrupt; high while state is READY.

## Operation
- States: IDLE, CAPTURE, READY.
- Register map, write side:
  - addr0 CTRL: bit0 START, bit1 ABORT.
  - addr1 NEXT: any write advances the playout pointer.
  - addr2 and addr3: writes ignored.
- Register map, read side:
  - addr0 STATUS: bit0 = (state == CAPTURE), bit1 = (state == READY).
  - addr1: wr_ptr.
  - addr2: rd_ptr.
  - addr3: 0.
- IDLE:
  - pio_data[31] = 0.
  - sample_valid is ignored.
  - START: wr_ptr <= 0, go to CAPTURE.
- CAPTURE:
  - Each sample_valid writes buffer[wr_ptr] and increments wr_ptr.
  - On the write at wr_ptr = 2^DEPTH_LOG2-1: go to READY, rd_ptr <= 0, wr_ptr wraps to 0.
- READY:
  - pio_data = {1, rd_ptr, buffer[rd_ptr]}.
  - NEXT increments rd_ptr.
  - NEXT at rd_ptr = 2^DEPTH_LOG2-1: go to IDLE, rd_ptr <= 0.
- START in CAPTURE restarts capture: wr_ptr <= 0, partial frame discarded.
- START in READY discards the frame and enters CAPTURE.
- ABORT in any state: go to IDLE, both pointers <= 0.
- Simultaneous ABORT and START in one write: ABORT wins.
- START coinciding with sample_valid: that sample is not stored; capture begins with the next strobe.
- NEXT outside READY: ignored.
- Buffer is inferred synchronous RAM: one write port, one registered read port.

## Timing
- Reset values:
  - readdata = 0, pio_data = 0, irq = 0.
  - state = IDLE, wr_ptr = 0, rd_ptr = 0.
- readdata is registered every cycle from address, with no read strobe.
- Register writes take effect on the clock edge where write = 1.
- STATUS reflects a write one cycle later in readdata.
- Frame entry:
  - Last capture write on edge T: state = READY and irq = 1 after T.
  - pio_data valid with sample 0 after edge T+2. pio_data[31] = 0 between T and T+2.
- NEXT on edge T:
  - rd_ptr updates at T.
  - pio_data[31] clears after T+1.
  - New {1, rd_ptr, sample} appears after T+2.
  - Software must wait 2 cycles before reading the PIO. Back-to-back NEXT writes are legal; every NEXT counts.
- Final NEXT on edge T: irq and pio_data[31] fall after T+1.
- Reset asserted mid-operation: all state returns to reset values immediately. Buffer contents are undefined and are not used.

## Test plan
- Reset: hold reset_n low, drive sample_valid and writes. Required: readdata = 0, pio_data = 0, irq = 0; after release, STATUS reads 0.
- Full frame, DEPTH_LOG2 = 3:
  - Stimulus: START, then 8 strobes of 0x1000+i.
  - Required: irq rises after the 8th strobe. pio_data = 0x80001000 two cycles later.
  - Then 7 NEXT writes. Required: pio_data = 0x80071007.
  - Then 1 more NEXT. Required: irq = 0, STATUS = 0.
- START in the same cycle as sample_valid(0xAAAA), then 8 strobes 0..7. Required: the first played-out sample is 0x0000, not 0xAAAA.
- Restart and abort:
  - START, 5 strobes, START again, 8 strobes. Required: frame holds only the last 8.
  - A write with START|ABORT together. Required: state IDLE, wr_ptr = 0.
- NEXT writes in IDLE and CAPTURE. Required: rd_ptr unchanged. sample_valid in IDLE: wr_ptr stays 0.
- Reset pulse in READY at rd_ptr = 3. Required: outputs 0 immediately; a new START/capture then works normally.
